// File: rtl/character_motion.sv
// Vertical motion controller for the flapping sprite: gravity, flap impulse,
// ceiling clamp, floor/collision death and the IDLE -> FLY -> DEAD game flow.
module character_motion #(
  parameter int START_X  = 100,
  parameter int START_Y  = 240,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int MAX_FALL = 8,
  parameter int Y_MIN    = 10,
  parameter int Y_MAX    = 470
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              flap,
  input  logic              start,
  input  logic              hit,
  output logic [9:0]        characterPositionX,
  output logic [9:0]        characterPositionY,
  output logic signed [5:0] velocity,
  output logic              alive,
  output logic              game_over
);

  typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

  localparam logic [9:0]         START_X10 = 10'(START_X);
  localparam logic [9:0]         START_Y10 = 10'(START_Y);
  localparam logic [9:0]         Y_MIN10   = 10'(Y_MIN);
  localparam logic [9:0]         Y_MAX10   = 10'(Y_MAX);
  localparam logic signed [10:0] GRAV11    = 11'(GRAVITY);
  localparam logic signed [10:0] FLAP11    = 11'(FLAP_VEL);
  localparam logic signed [10:0] MAXF11    = 11'(MAX_FALL);
  localparam logic signed [10:0] YMIN11    = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX11    = 11'(Y_MAX);

  state_t state;
  logic flap_q;
  logic flap_pending;
  logic flap_edge;
  logic ceiling_hit;
  logic floor_hit;
  logic signed [10:0] vel_ext;
  logic signed [10:0] vel_sum;
  logic signed [10:0] vel_new;
  logic signed [10:0] y_next;

  // Next-frame physics, evaluated in 11-bit signed so the sum can never wrap.
  always_comb begin
    flap_edge = flap & ~flap_q;
    vel_ext   = {{5{velocity[5]}}, velocity};
    vel_sum   = vel_ext + GRAV11;
    if (flap_pending)
      vel_new = FLAP11;
    else if (vel_sum > MAXF11)
      vel_new = MAXF11;
    else
      vel_new = vel_sum;
    y_next      = $signed({1'b0, characterPositionY}) + vel_new;
    ceiling_hit = (y_next <= YMIN11);
    floor_hit   = frame_tick && !ceiling_hit && (y_next >= YMAX11);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      characterPositionX <= START_X10;
      characterPositionY <= START_Y10;
      velocity           <= '0;
      alive              <= 1'b0;
      game_over          <= 1'b0;
      flap_q             <= 1'b0;
      flap_pending       <= 1'b0;
    end else begin
      flap_q             <= flap;
      characterPositionX <= START_X10;
      alive              <= 1'b0;
      game_over          <= 1'b0;
      case (state)
        IDLE: begin
          characterPositionY <= START_Y10;
          velocity           <= '0;
          flap_pending       <= flap_edge;
          if (start || flap_edge) begin
            state <= FLY;
            alive <= 1'b1;
          end
        end
        FLY: begin
          // An edge arriving on the consuming tick survives for the next tick.
          if (frame_tick) begin
            flap_pending <= flap_edge;
            if (ceiling_hit) begin
              characterPositionY <= Y_MIN10;
              velocity           <= '0;
            end else if (floor_hit) begin
              characterPositionY <= Y_MAX10;
              velocity           <= '0;
            end else begin
              characterPositionY <= y_next[9:0];
              velocity           <= vel_new[5:0];
            end
          end else begin
            flap_pending <= flap_pending | flap_edge;
          end
          if (floor_hit || hit) begin
            state     <= DEAD;
            game_over <= 1'b1;
          end else begin
            alive <= 1'b1;
          end
        end
        DEAD: begin
          flap_pending <= 1'b0;
          if (start) begin
            state              <= IDLE;
            characterPositionY <= START_Y10;
            velocity           <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_character_motion.sv
// Self-checking bench for character_motion: directed vector table, corner
// sequences and a randomized run against a behavioural model.
module tb_character_motion;

  localparam int START_X  = 100;
  localparam int START_Y  = 240;
  localparam int GRAVITY  = 1;
  localparam int FLAP_VEL = -8;
  localparam int MAX_FALL = 8;
  localparam int Y_MIN    = 10;
  localparam int Y_MAX    = 470;

  localparam int M_IDLE = 0;
  localparam int M_FLY  = 1;
  localparam int M_DEAD = 2;

  logic clk = 1'b0;
  logic rst, frame_tick, flap, start, hit;
  logic [9:0] posX, posY;
  logic signed [5:0] vel;
  logic alive, game_over;

  int total = 0;
  int bad = 0;

  int mState, mY, mV;
  bit mAlive, mGo, mPrevFlap, mPend;

  typedef struct {
    bit t;
    bit f;
    bit s;
    bit h;
    int y;
    int v;
    bit a;
    bit g;
  } vec_t;

  vec_t vecs[17];

  character_motion dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .flap(flap),
    .start(start),
    .hit(hit),
    .characterPositionX(posX),
    .characterPositionY(posY),
    .velocity(vel),
    .alive(alive),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mState = M_IDLE; mY = START_Y; mV = 0;
    mAlive = 0; mGo = 0; mPrevFlap = 0; mPend = 0;
  endfunction

  // Game rules expressed with plain integer arithmetic.
  function automatic void modelStep(bit t, bit f, bit s, bit h);
    int nv, ny;
    bit edgeSeen, died;
    edgeSeen = f && !mPrevFlap;
    mPrevFlap = f;
    mGo = 0;
    died = 0;
    if (mState == M_IDLE) begin
      mY = START_Y; mV = 0; mPend = edgeSeen;
      if (s || edgeSeen) mState = M_FLY;
    end else if (mState == M_FLY) begin
      if (t) begin
        if (mPend) nv = FLAP_VEL;
        else nv = (mV + GRAVITY > MAX_FALL) ? MAX_FALL : mV + GRAVITY;
        ny = mY + nv;
        mPend = edgeSeen;
        if (ny <= Y_MIN) begin mY = Y_MIN; mV = 0; end
        else if (ny >= Y_MAX) begin mY = Y_MAX; mV = 0; died = 1; end
        else begin mY = ny; mV = nv; end
      end else if (edgeSeen) begin
        mPend = 1;
      end
      if (died || h) begin mState = M_DEAD; mGo = 1; end
    end else begin
      mPend = 0;
      if (s) begin mState = M_IDLE; mY = START_Y; mV = 0; end
    end
    mAlive = (mState == M_FLY);
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".x"}, int'(posX), START_X);
    checkValue({tag, ".y"}, int'(posY), mY);
    checkValue({tag, ".vel"}, int'(vel), mV);
    checkValue({tag, ".alive"}, int'(alive), int'(mAlive));
    checkValue({tag, ".game_over"}, int'(game_over), int'(mGo));
  endtask

  task automatic applyStimulus(input bit t, input bit f, input bit s, input bit h);
    frame_tick = t; flap = f; start = s; hit = h;
    @(posedge clk);
    #1;
    modelStep(t, f, s, h);
  endtask

  task automatic cyc(input bit t, input bit f, input bit s, input bit h, input string tag);
    applyStimulus(t, f, s, h);
    checkOutput(tag);
  endtask

  task automatic flapTick(input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, tag);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // From IDLE, climbs slightly then falls until Y=465 with velocity=8.
  task automatic goTo465(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, tag);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
    flapTick(tag);
    for (int i = 0; i < 44; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
    checkValue({tag, ".y465"}, int'(posY), 465);
    checkValue({tag, ".v8"}, int'(vel), 8);
  endtask

  initial begin
    int pulses;
    bit fl;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 240,  0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 241,  1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 241,  1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 243,  2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 246,  3, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 246,  3, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 246,  3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 246,  3, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 238, -8, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 231, -7, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 231, -7, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 231, -7, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 231, -7, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 240,  0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 240,  0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 232, -8, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 225, -7, 1'b1, 1'b0};

    rst = 1'b1; frame_tick = 1'b0; flap = 1'b0; start = 1'b0; hit = 1'b0;
    modelReset();
    #12;
    checkValue("reset.x", int'(posX), 100);
    checkValue("reset.y", int'(posY), 240);
    checkValue("reset.vel", int'(vel), 0);
    checkValue("reset.alive", int'(alive), 0);
    checkValue("reset.game_over", int'(game_over), 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].t, vecs[i].f, vecs[i].s, vecs[i].h);
      checkValue($sformatf("vec%0d.y", i), int'(posY), vecs[i].y);
      checkValue($sformatf("vec%0d.vel", i), int'(vel), vecs[i].v);
      checkValue($sformatf("vec%0d.alive", i), int'(alive), int'(vecs[i].a));
      checkValue($sformatf("vec%0d.game_over", i), int'(game_over), int'(vecs[i].g));
    end
    checkValue("vec.x", int'(posX), 100);

    // Asynchronous reset in the middle of a clock period while flying.
    frame_tick = 1'b0; flap = 1'b0; start = 1'b0; hit = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkValue("async.x", int'(posX), 100);
    checkValue("async.y", int'(posY), 240);
    checkValue("async.vel", int'(vel), 0);
    checkValue("async.alive", int'(alive), 0);
    checkValue("async.game_over", int'(game_over), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ceiling clamp from Y=14.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "ceil");
    flapTick("ceil");
    flapTick("ceil");
    for (int i = 0; i < 14; i++) begin
      flapTick("ceil");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, "ceil");
    end
    checkValue("ceil.y14", int'(posY), 14);
    flapTick("ceil");
    checkValue("ceil.clampY", int'(posY), 10);
    checkValue("ceil.clampV", int'(vel), 0);
    checkValue("ceil.stillFly", int'(alive), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "ceil");
    checkValue("ceil.afterY", int'(posY), 11);

    // Floor crossing: single game_over pulse, frozen afterwards.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "floor");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "floor");
    goTo465("floor");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "floor");
    checkValue("floor.y", int'(posY), 470);
    checkValue("floor.go", int'(game_over), 1);
    checkValue("floor.alive", int'(alive), 0);
    checkValue("floor.vel", int'(vel), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "dead");
      checkValue("dead.go", int'(game_over), 0);
      checkValue("dead.y", int'(posY), 470);
    end

    // Hit coincident with floor tick, then restart.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "both");
    goTo465("both");
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("both");
    pulses += int'(game_over);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "both");
      pulses += int'(game_over);
    end
    checkValue("both.pulses", pulses, 1);
    checkValue("both.y", int'(posY), 470);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "restart");
    checkValue("restart.y", int'(posY), 240);
    checkValue("restart.alive", int'(alive), 0);

    // Randomized run against the model.
    fl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) fl = !fl;
      cyc($urandom_range(0, 3) == 0, fl, $urandom_range(0, 39) == 0,
          $urandom_range(0, 79) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/character_motion.md
CHARACTER_MOTION -- requirements
Module: character_motion

Interface
REQ-001 Parameter START_X, default 100: characterPositionX value; constant in every state.
REQ-002 Parameter START_Y, default 240: characterPositionY after reset and on re-entry to IDLE.
REQ-003 Parameter GRAVITY, default 1: velocity increment per frame while falling.
REQ-004 Parameter FLAP_VEL, default -8: signed velocity loaded on a flap.
REQ-005 Parameter MAX_FALL, default 8: positive velocity ceiling.
REQ-006 Parameter Y_MIN, default 10: topmost legal Y.
REQ-007 Parameter Y_MAX, default 470: floor Y.
REQ-008 Port clk, input, 1: single clock for the block.
REQ-009 Port rst, input, 1: reset, asynchronous and active-high.
REQ-010 Port frame_tick, input, 1: one-cycle pulse at start of vertical blanking.
REQ-011 Port flap, input, 1: level from a button already synchronised to clk.
REQ-012 Port start, input, 1: one-cycle pulse requesting game start or restart.
REQ-013 Port hit, input, 1: level from pipe collision logic.
REQ-014 Port characterPositionX, output, 10: sprite centre X, fed to the sprite renderer.
REQ-015 Port characterPositionY, output, 10: sprite centre Y, fed to the sprite renderer.
REQ-016 Port velocity, output, 6: signed two's-complement current velocity.
REQ-017 Port alive, output, 1: high in FLY only.
REQ-018 Port game_over, output, 1: one-cycle pulse on entry to DEAD.

Function
REQ-019 The block SHALL implement states IDLE, FLY and DEAD; all outputs SHALL be registered.
REQ-020 Flap detection SHALL register flap and set flap_pending on a 0->1 edge; multiple edges between ticks SHALL count once.
REQ-021 flap_pending SHALL clear on the frame_tick that consumes it; an edge coincident with that tick SHALL stay pending for the next tick.
REQ-022 IDLE: Y=START_Y, velocity=0; frame_tick SHALL be ignored; hit SHALL be ignored.
REQ-023 IDLE: start pulse or flap edge SHALL move to FLY next cycle, velocity=0; a flap edge SHALL also set flap_pending.
REQ-024 Position and velocity SHALL change only on a cycle with frame_tick=1 in FLY; between ticks they SHALL hold.
REQ-025 FLY tick, flap_pending=1: vel_new=FLAP_VEL; else vel_new=min(velocity+GRAVITY, MAX_FALL).
REQ-026 FLY tick: y_next=Y+vel_new, computed in 11-bit signed so no wrap occurs; latency 1 clk from tick.
REQ-027 If y_next<=Y_MIN: Y=Y_MIN, velocity=0, remain FLY.
REQ-028 If y_next>=Y_MAX: Y=Y_MAX, velocity=0, go DEAD, game_over=1 for one cycle.
REQ-029 hit=1 on any FLY cycle SHALL go DEAD next cycle with game_over pulse; Y/velocity SHALL freeze at current values unless the same-cycle tick applies REQ-025..028 first.
REQ-030 Simultaneous hit and floor in one cycle SHALL produce exactly one game_over pulse.
REQ-031 DEAD: position/velocity frozen; frame_tick, flap and hit ignored; flap_pending cleared.
REQ-032 DEAD: start SHALL go to IDLE next cycle with Y=START_Y, velocity=0.
REQ-033 start in FLY SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, characterPositionX=START_X, Y=START_Y, velocity=0, alive=0, game_over=0, flap_pending=0, flap register=0.
REQ-035 Reset asserted mid-FLY or mid-pulse SHALL abort all activity; no game_over SHALL be emitted on reset.

Verification
REQ-036 Assert rst mid-cycle -> X=100, Y=240, velocity=0, alive=0 without waiting for a clk edge.
REQ-037 start, then 3 ticks with no flap -> velocity 1,2,3; Y 241,243,246; alive=1.
REQ-038 From Y=246, flap pulsed twice, then 1 tick -> velocity=-8, Y=238; next tick -> velocity=-7, Y=231.
REQ-039 Y=14, flap then tick -> Y=10, velocity=0, still FLY.
REQ-040 Y=465, velocity=8, tick -> Y=470, DEAD, game_over high exactly 1 cycle; later ticks leave Y=470.
REQ-041 hit mid-line in FLY coincident with a floor-crossing tick -> single game_over pulse; start -> IDLE with Y=240 the next cycle.
